// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad front end: matrix size,
// debounce FSM states, per-scan classification and key legends.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_PRESSED,
        ST_RELEASE
    } key_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_result_t;

    // Key code is {row[1:0], col[1:0]}; legends as wired on the calculator panel.
    localparam logic [3:0] KEY_D0    = 4'h0;
    localparam logic [3:0] KEY_D1    = 4'h1;
    localparam logic [3:0] KEY_D2    = 4'h2;
    localparam logic [3:0] KEY_D3    = 4'h3;
    localparam logic [3:0] KEY_D4    = 4'h4;
    localparam logic [3:0] KEY_D5    = 4'h5;
    localparam logic [3:0] KEY_D6    = 4'h6;
    localparam logic [3:0] KEY_D7    = 4'h7;
    localparam logic [3:0] KEY_D8    = 4'h8;
    localparam logic [3:0] KEY_D9    = 4'h9;
    localparam logic [3:0] KEY_LOAD  = 4'hA;
    localparam logic [3:0] KEY_SUM   = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_SPARE = 4'hD;

    function automatic scan_result_t scan_classify(input logic [ROWS*COLS-1:0] hits);
        int unsigned n;
        n = $countones(hits);
        if (n == 0)
            return SCAN_NONE;
        else if (n == 1)
            return SCAN_SINGLE;
        else
            return SCAN_MULTI;
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Debounce / acceptance FSM, stepped once per completed keypad scan.
// Produces the held key code, a one-cycle acceptance strobe and a held flag.
module key_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         scan_done,
    input  scan_result_t scan_result,
    input  logic [3:0]   scan_code,
    output logic [3:0]   key_code,
    output logic         key_valid,
    output logic         key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    key_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       cand_reg, cand_next;
    logic [3:0]       code_reg, code_next;
    logic             valid_reg, valid_next;
    logic             held_reg, held_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            cand_reg  <= '0;
            code_reg  <= '0;
            valid_reg <= 1'b0;
            held_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            code_reg  <= code_next;
            valid_reg <= valid_next;
            held_reg  <= held_next;
        end
    end

    // The counter only ever increments below CNT_LAST, so it saturates by construction.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        code_next  = code_reg;
        valid_next = 1'b0;
        held_next  = held_reg;
        if (scan_done) begin
            case (state_reg)
                ST_IDLE: begin
                    if (scan_result == SCAN_SINGLE) begin
                        state_next = ST_CONFIRM;
                        cand_next  = scan_code;
                        cnt_next   = CNT_ONE;
                    end
                end
                ST_CONFIRM: begin
                    if (scan_result == SCAN_SINGLE) begin
                        if (scan_code != cand_reg) begin
                            cand_next = scan_code;
                            cnt_next  = CNT_ONE;
                        end else if (cnt_reg >= CNT_LAST) begin
                            state_next = ST_PRESSED;
                            code_next  = cand_reg;
                            valid_next = 1'b1;
                            held_next  = 1'b1;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (scan_result == SCAN_NONE) begin
                        state_next = ST_RELEASE;
                        cnt_next   = CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (scan_result != SCAN_NONE) begin
                        // Re-contact or rollover: stay down silently.
                        state_next = ST_PRESSED;
                        cnt_next   = '0;
                    end else if (cnt_reg >= CNT_LAST) begin
                        state_next = ST_IDLE;
                        held_next  = 1'b0;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    held_next  = 1'b0;
                end
            endcase
        end
    end

    assign key_code  = code_reg;
    assign key_valid = valid_reg;
    assign key_held  = held_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, samples the
// synchronized rows at the end of each slot and hands full-scan results to the debouncer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    logic [3:0]            row_meta_reg, row_sync_reg;
    logic [SLOT_W-1:0]     slot_reg, slot_next;
    logic [1:0]            col_idx_reg, col_idx_next;
    logic [ROWS*COLS-1:0]  acc_reg, acc_next;
    logic [ROWS*COLS-1:0]  sample_bits, merged;
    logic                  slot_last, scan_done;
    scan_result_t          scan_result;
    logic [3:0]            scan_code;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            row_meta_reg <= '1;
            row_sync_reg <= '1;
            slot_reg     <= '0;
            col_idx_reg  <= '0;
            acc_reg      <= '0;
        end else begin
            row_meta_reg <= row_n;
            row_sync_reg <= row_meta_reg;
            slot_reg     <= slot_next;
            col_idx_reg  <= col_idx_next;
            acc_reg      <= acc_next;
        end
    end

    assign slot_last    = (slot_reg == SLOT_LAST);
    assign scan_done    = slot_last && (col_idx_reg == 2'd3);
    assign slot_next    = slot_last ? '0 : slot_reg + SLOT_W'(1);
    assign col_idx_next = slot_last ? col_idx_reg + 2'd1 : col_idx_reg;
    assign col_n        = ~(4'b0001 << col_idx_reg);

    // Accumulator bit index equals the key code {row, col}.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS*COLS; gi++) begin : g_sample
            assign sample_bits[gi] = (col_idx_reg == 2'(gi % COLS)) && !row_sync_reg[gi / COLS];
        end
    endgenerate

    assign merged   = acc_reg | (slot_last ? sample_bits : '0);
    assign acc_next = scan_done ? '0 : merged;

    always_comb begin
        scan_code = '0;
        for (int i = 0; i < ROWS*COLS; i++) begin
            if (merged[i])
                scan_code = 4'(i);
        end
    end

    assign scan_result = scan_classify(merged);

    key_debounce_fsm #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (sys_clk),
        .srst       (sys_rst),
        .scan_done  (scan_done),
        .scan_result(scan_result),
        .scan_code  (scan_code),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Upstream input stage for the calculator top level. It scans a 4x4 matrix keypad and debounces the result. It delivers one clean 4-bit key code per physical press, plus a single-cycle strobe. This replaces the raw key_pad/test bus and absorbs contact bounce before load/sum/clr logic sees it.

Parameters:
SCAN_DIV, 1000, clock cycles each column stays driven; legal range is 4 or more.
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a press or release; legal range is 2 to 15.

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
col_n  out  4  column drive, active-low, exactly one bit low at all times
row_n  in  4  raw row sense, active-low, asynchronous and bouncy
key_code  out  4  code of last accepted key, equal to {row[1:0], col[1:0]}, held until next acceptance
key_valid  out  1  one-cycle strobe, asserted in the cycle key_code updates
key_held  out  1  high while the accepted key is considered down

Behaviour:
- Reset (sync, sys_rst=1 at clock edge):
  - col_n=4'b1110, key_code=0, key_valid=0, key_held=0.
  - FSM=IDLE; slot counter, column index, debounce counter and scan accumulator all cleared.
  - Reset mid-press discards all progress and emits no strobe.
- row_n passes through a 2-flop synchronizer before any use.
- Column rotation:
  - Slot counter runs 0..SCAN_DIV-1.
  - Column index advances on wrap: 0->1->2->3->0.
  - col_n = ~(1<<idx).
- Sampling:
  - In the last cycle of each slot (counter = SCAN_DIV-1), the synchronized rows are merged into the scan accumulator for that column.
  - SCAN_DIV>=4 guarantees settle time plus synchronizer latency.
- Scan result:
  - Evaluated once per full scan, at the end of the column-3 slot (scan period = 4*SCAN_DIV cycles). The accumulator then clears.
  - NONE = zero active contacts.
  - SINGLE(code) = exactly one active contact.
  - MULTI = two or more active contacts (ghosting). MULTI never produces a code.
- FSM, stepped only at scan evaluation; counter cnt:
  - IDLE: SINGLE(k) -> CONFIRM, cand=k, cnt=1. NONE or MULTI -> stay in IDLE.
  - CONFIRM:
    - SINGLE(cand) -> cnt++. When cnt reaches DEBOUNCE_SCANS -> PRESSED, key_code=cand, key_valid=1 for one cycle.
    - SINGLE(other) -> restart CONFIRM, cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED: key_held=1. NONE -> RELEASE, cnt=1. SINGLE or MULTI -> stay in PRESSED.
  - RELEASE:
    - NONE -> cnt++. At DEBOUNCE_SCANS -> IDLE, key_held=0.
    - SINGLE or MULTI -> back to PRESSED, with no new strobe even if the key differs (rollover is ignored).
- key_held:
  - Rises in the same cycle as key_valid.
  - Falls in the cycle the FSM enters IDLE from RELEASE.
  - Stays high through RELEASE.
- Latency: the press is accepted at the DEBOUNCE_SCANS-th consecutive matching scan evaluation after contact becomes stable. A full scan is 4*SCAN_DIV cycles.
- Boundary rules:
  - A bounce shorter than one scan can only reset CONFIRM; it never yields a strobe.
  - At most one key_valid per press-release cycle.
  - cnt saturates and cannot wrap.
  - Counter widths are sized with $clog2 of the parameters.

Decomposition:
- Shared package keypad_pkg holds:
  - ROWS=4, COLS=4.
  - FSM state encoding (IDLE, CONFIRM, PRESSED, RELEASE).
  - Scan-result encoding (NONE, SINGLE, MULTI).
  - Key-code constants mapping codes to legends (digits 0-9, LOAD, SUM, CLR, spare).
- One sub-module, key_debounce_fsm:
  - Inputs: a scan_done pulse and the scan result/code.
  - Owns the FSM, cnt, key_code, key_valid and key_held.
  - The parent keeps the column driver, synchronizer and accumulator.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan period 16 cycles; bench models the matrix as row_n[r]=0 iff col_n[c]=0 and key (r,c) is pressed):
- Reset then idle 200 cycles -> col_n cycles 1110,1101,1011,0111 with 4 cycles each; key_valid never asserted; key_code=0.
- Press (r=1,c=2), held clean -> key_valid pulses exactly once with key_code=4'h6 at the 3rd scan evaluation after the press; key_held=1.
- Press (2,0) toggled every 6 cycles for 40 cycles, then held -> no strobe during the bounce; exactly one strobe with key_code=4'h8 afterwards.
- Hold (0,1) and (0,3) together from IDLE -> MULTI is reported; no strobe; key_held stays 0.
- Accept (3,3), release with one bouncing re-contact during RELEASE, then full release -> no second strobe; key_held falls 3 clean scans after the final release.
- sys_rst=1 while in CONFIRM with cnt=2 -> all outputs at reset values next cycle; col_n=1110; a fresh press needs 3 full scans again.
